// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: pops one header, streams three header words and
// then the event's samples as a 32-bit valid/ready stream, and publishes the release pointer.
//
// state  | meaning
// S_IDLE | waiting for en and a queued header
// S_H0   | dout holds H0 (marker + event length)
// S_H1   | dout holds H1 (ltc upper bits)
// S_H2   | dout holds H2 (ltc lower bits + trigger info)
// S_SAMP | dout holds samples; prefetched RAM data drains from the skid FIFO
// S_DONE | release pointer updated, evt_done pulsed
module wvb_rd_ctrl #(
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80,
   parameter int P_LTC_WIDTH  = 48
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic                    en,
   input  logic                    hdr_empty,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data,
   output logic                    hdr_rden,
   output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
   output logic [31:0]             dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [P_ADR_WIDTH-1:0]  rd_ptr,
   output logic                    evt_done,
   output logic                    busy
);
   localparam int LW = P_ADR_WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_H0, S_H1, S_H2, S_SAMP, S_DONE} state_t;

   state_t                   state_q;
   logic [P_LTC_WIDTH-1:0]   ltc_q;
   logic [P_ADR_WIDTH-1:0]   stop_q;
   logic [1:0]               trig_q;
   logic                     cnst_q;
   logic [4:0]               pre_q;
   logic [P_ADR_WIDTH-1:0]   rd_addr_q;
   logic [P_ADR_WIDTH-1:0]   rd_ptr_q;
   logic [LW-1:0]            iss_rem_q;
   logic [LW-1:0]            load_rem_q;
   logic                     inflight_q;
   logic [31:0]              dout_q;
   logic                     valid_q;
   logic                     evt_done_q;
   logic                     busy_q;
   logic [P_DATA_WIDTH-1:0]  fifo_q [4];
   logic [2:0]               fwr_q;
   logic [2:0]               frd_q;

   logic [P_ADR_WIDTH-1:0]   hdr_start;
   logic [P_ADR_WIDTH-1:0]   hdr_stop;
   logic [P_ADR_WIDTH-1:0]   len_mod;
   logic [LW-1:0]            hdr_len;
   logic [2:0]               fcnt;
   logic                     in_evt;
   logic                     adv;
   logic                     rd_issue;
   logic                     load_samp;

   always_comb begin
      hdr_start = P_ADR_WIDTH'(hdr_data[31:20]);
      hdr_stop  = P_ADR_WIDTH'(hdr_data[19:8]);
      len_mod   = hdr_stop - hdr_start + P_ADR_WIDTH'(1);
      // a zero modulo length means the event spans the whole buffer
      hdr_len   = (len_mod == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, len_mod};
      fcnt      = fwr_q - frd_q;
      in_evt    = (state_q == S_H0) || (state_q == S_H1) || (state_q == S_H2) || (state_q == S_SAMP);
      adv       = !valid_q || dout_ready;
      // credit check: FIFO occupancy plus the read in flight never exceeds the 4 entries
      rd_issue  = in_evt && (iss_rem_q != '0) && ((fcnt + {2'b00, inflight_q}) <= 3'd3);
      load_samp = adv && (fcnt != 3'd0) && (load_rem_q != '0)
                  && ((state_q == S_H2) || (state_q == S_SAMP));
      hdr_rden  = !i_rst && (state_q == S_IDLE) && en && !hdr_empty;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         ltc_q      <= '0;
         stop_q     <= '0;
         trig_q     <= '0;
         cnst_q     <= 1'b0;
         pre_q      <= '0;
         rd_addr_q  <= '0;
         rd_ptr_q   <= '0;
         iss_rem_q  <= '0;
         load_rem_q <= '0;
         inflight_q <= 1'b0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         evt_done_q <= 1'b0;
         busy_q     <= 1'b0;
         fwr_q      <= '0;
         frd_q      <= '0;
      end else begin
         evt_done_q <= 1'b0;
         inflight_q <= rd_issue;
         if (rd_issue) begin
            rd_addr_q <= rd_addr_q + P_ADR_WIDTH'(1);
            iss_rem_q <= iss_rem_q - LW'(1);
         end
         if (inflight_q) begin
            fifo_q[fwr_q[1:0]] <= wvb_rd_data;
            fwr_q <= fwr_q + 3'd1;
         end
         if (load_samp) begin
            dout_q     <= 32'(fifo_q[frd_q[1:0]]);
            valid_q    <= 1'b1;
            frd_q      <= frd_q + 3'd1;
            load_rem_q <= load_rem_q - LW'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (hdr_rden) begin
                  ltc_q      <= hdr_data[79:32];
                  stop_q     <= hdr_stop;
                  trig_q     <= hdr_data[7:6];
                  cnst_q     <= hdr_data[5];
                  pre_q      <= hdr_data[4:0];
                  rd_addr_q  <= hdr_start;
                  iss_rem_q  <= hdr_len;
                  load_rem_q <= hdr_len;
                  dout_q     <= {16'hE5A5, 16'(hdr_len)};
                  valid_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_H0;
               end
            end
            S_H0: begin
               if (dout_ready) begin
                  dout_q  <= ltc_q[47:16];
                  state_q <= S_H1;
               end
            end
            S_H1: begin
               if (dout_ready) begin
                  dout_q  <= {ltc_q[15:0], 5'b0, trig_q, cnst_q, 3'b0, pre_q};
                  state_q <= S_H2;
               end
            end
            S_H2: begin
               if (dout_ready) begin
                  if (!load_samp) valid_q <= 1'b0;
                  state_q <= S_SAMP;
               end
            end
            S_SAMP: begin
               if (adv && !load_samp) begin
                  valid_q <= 1'b0;
                  if (load_rem_q == '0) begin
                     rd_ptr_q   <= stop_q + P_ADR_WIDTH'(1);
                     evt_done_q <= 1'b1;
                     state_q    <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wvb_rd_addr = rd_addr_q;
   assign dout        = dout_q;
   assign dout_valid  = valid_q;
   assign rd_ptr      = rd_ptr_q;
   assign evt_done    = evt_done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Bench for wvb_rd_ctrl: header FIFO and RAM models, an expected-word queue built from
// each popped header, and directed phases with random data and random backpressure.
module tb_wvb_rd_ctrl;
   localparam int DW = 22;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          i_rst, en, hdr_empty, hdr_rden;
   logic [79:0]   hdr_data;
   logic [AW-1:0] wvb_rd_addr, rd_ptr;
   logic [DW-1:0] wvb_rd_data;
   logic [31:0]   dout;
   logic          dout_valid, dout_ready, evt_done, busy;

   logic [DW-1:0] ram [0:4095];
   logic [79:0]   hdr_mem [0:15];
   logic [4:0]    wr_i;
   logic [4:0]    rd_i = '0;

   logic [31:0]   exp_q [$];
   logic [AW-1:0] exp_rdptr;
   int            cyc, pop_cyc, done_due, stalls, ev_len, n_done, n_pop, last_done_cyc, gap;
   bit            rnd_ready;
   int            errs, checks;

   wvb_rd_ctrl dut (
      .clk(clk), .i_rst(i_rst), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
      .hdr_rden(hdr_rden), .wvb_rd_addr(wvb_rd_addr), .wvb_rd_data(wvb_rd_data),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .rd_ptr(rd_ptr),
      .evt_done(evt_done), .busy(busy)
   );

   always #5 clk = ~clk;

   assign hdr_empty = (rd_i == wr_i);
   assign hdr_data  = hdr_mem[rd_i[3:0]];

   always @(posedge clk) begin
      if (hdr_rden) rd_i <= rd_i + 5'd1;
      wvb_rd_data <= ram[wvb_rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_hdr(input logic [11:0] st, input logic [11:0] sp, input logic [47:0] ltc,
                           input logic [1:0] trig, input logic cnst, input logic [4:0] pre);
      hdr_mem[wr_i[3:0]] = {ltc, st, sp, trig, cnst, pre};
      wr_i = wr_i + 5'd1;
   endtask

   task automatic push_rand(input int len);
      logic [63:0] r;
      logic [11:0] st;
      r  = {$urandom, $urandom};
      st = 12'($urandom);
      push_hdr(st, st + 12'(len - 1), r[47:0], r[49:48], r[50], r[55:51]);
   endtask

   // expected stream for a popped header, derived from the header layout and RAM contents
   task automatic model_pop();
      logic [79:0] h;
      int st, sp;
      h  = hdr_mem[rd_i[3:0]];
      st = int'(h[31:20]);
      sp = int'(h[19:8]);
      ev_len = ((sp - st) & 32'hFFF) + 1;
      exp_q.push_back({16'hE5A5, 16'(ev_len)});
      exp_q.push_back(h[79:48]);
      exp_q.push_back({h[47:32], 5'b0, h[7:6], h[5], 3'b0, h[4:0]});
      for (int i = 0; i < ev_len; i++) exp_q.push_back(32'(ram[(st + i) % 4096]));
      exp_rdptr = 12'(sp + 1);
      stalls = 0;
      pop_cyc = cyc;
      gap = cyc - last_done_cyc;
      n_pop++;
   endtask

   task automatic step();
      @(negedge clk);
      if (i_rst) begin
         exp_q.delete();
         done_due = -1;
      end else begin
         if (hdr_rden) model_pop();
         if (dout_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 64'(dout), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               chk("dout", 64'(dout), 64'(exp_q[0]));
               if (dout_ready) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) begin
                     chk("event_cycles", 64'(cyc - pop_cyc - stalls), 64'(3 + ev_len));
                     done_due = cyc + 1;
                  end
               end else stalls++;
            end
         end
         if (evt_done || cyc == done_due) begin
            chk("evt_done_timing", {62'b0, evt_done, 1'b1}, {62'b0, 1'b1, cyc == done_due});
            chk("rd_ptr", 64'(rd_ptr), 64'(exp_rdptr));
            n_done++;
            last_done_cyc = cyc;
            done_due = -1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input int target, input int max_cyc);
      int k;
      k = 0;
      while (n_done < target && k < max_cyc) begin
         step();
         k++;
      end
      chk("evt_count", 64'(n_done), 64'(target));
   endtask

   initial begin
      int p0, nd, k;
      i_rst = 1'b1; en = 1'b0; dout_ready = 1'b1; rnd_ready = 1'b0; wr_i = '0;
      cyc = 0; done_due = -1; n_done = 0; n_pop = 0; last_done_cyc = -1000; gap = 0;
      errs = 0; checks = 0; stalls = 0; ev_len = 0; pop_cyc = 0; exp_rdptr = '0;
      for (int a = 0; a < 4096; a++) ram[a] = DW'($urandom);
      repeat (3) step();
      chk("rst_hdr_rden", 64'(hdr_rden), 64'd0);
      chk("rst_rd_addr", 64'(wvb_rd_addr), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
      chk("rst_evt_done", 64'(evt_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      i_rst = 1'b0;
      step();

      // single event with RAM[a] = a
      for (int a = 16; a <= 20; a++) ram[a] = DW'(a);
      push_hdr(12'h010, 12'h014, 48'h1234_5678_9ABC, 2'd1, 1'b0, 5'd5);
      en = 1'b1;
      wait_done(1, 60);
      chk("single_rd_ptr", 64'(rd_ptr), 64'h015);
      chk("single_busy_after", 64'(busy), 64'd0);

      // wrap past the top of the buffer, then a full-buffer event
      push_hdr(12'hFFE, 12'h001, 48'hA5A5_0000_1111, 2'd2, 1'b1, 5'd17);
      wait_done(2, 60);
      chk("wrap_rd_ptr", 64'(rd_ptr), 64'h002);
      push_hdr(12'h100, 12'h0FF, 48'h0000_FFFF_0000, 2'd3, 1'b0, 5'd31);
      wait_done(3, 4200);
      chk("full_rd_ptr", 64'(rd_ptr), 64'h100);

      // random backpressure: single events, then three queued back to back
      rnd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nd = n_done;
         push_rand(int'($urandom_range(1, 40)));
         wait_done(nd + 1, 300);
      end
      nd = n_done;
      for (int i = 0; i < 3; i++) push_rand(int'($urandom_range(1, 30)));
      wait_done(nd + 3, 600);

      // en dropped mid-event must not truncate it
      nd = n_done;
      push_rand(40);
      k = 0;
      while (!busy && k < 20) begin step(); k++; end
      repeat (3) step();
      en = 1'b0;
      wait_done(nd + 1, 400);
      en = 1'b1;

      // gating: header waiting with en low
      rnd_ready = 1'b0; dout_ready = 1'b1;
      en = 1'b0;
      push_rand(6);
      p0 = n_pop;
      repeat (100) step();
      chk("gate_no_pop", 64'(n_pop - p0), 64'd0);
      nd = n_done;
      en = 1'b1;
      wait_done(nd + 1, 60);

      // reset in the middle of the sample phase
      nd = n_done;
      push_hdr(12'h200, 12'h21F, 48'h0102_0304_0506, 2'd0, 1'b1, 5'd3);
      k = 0;
      while (!(busy && cyc - pop_cyc >= 8) && k < 40) begin step(); k++; end
      i_rst = 1'b1;
      step();
      step();
      chk("mid_rst_hdr_rden", 64'(hdr_rden), 64'd0);
      chk("mid_rst_rd_addr", 64'(wvb_rd_addr), 64'd0);
      chk("mid_rst_dout", 64'(dout), 64'd0);
      chk("mid_rst_valid", 64'(dout_valid), 64'd0);
      chk("mid_rst_rd_ptr", 64'(rd_ptr), 64'd0);
      chk("mid_rst_evt_done", 64'(evt_done), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      i_rst = 1'b0;
      push_hdr(12'h000, 12'h002, 48'hCAFE_BABE_0042, 2'd1, 1'b1, 5'd9);
      wait_done(nd + 1, 60);
      chk("post_rst_rd_ptr", 64'(rd_ptr), 64'h003);

      // back-to-back: second pop exactly one cycle after the first evt_done
      nd = n_done;
      push_rand(int'($urandom_range(2, 12)));
      push_rand(int'($urandom_range(2, 12)));
      wait_done(nd + 2, 200);
      chk("b2b_gap", 64'(gap), 64'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
